// File: rtl/capture_pkg.sv
// capture_pkg: shared types and sizing for the sample capture write path.
// Holds the capture state encoding and the post-trigger count helper.
package capture_pkg;

    localparam int ADDR_W   = 12;
    localparam int SAMPLE_W = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ARMED = 2'd1,
        POST  = 2'd2,
        DONE  = 2'd3
    } state_t;

    // Samples recorded after the trigger fill the rest of the ring.
    function automatic int post_count(int addr_w, int pre);
        return (1 << addr_w) - pre;
    endfunction

endpackage

// File: rtl/capture_writer_if.sv
// capture_writer_if: ADC sample input and RAM write port of the capture path.
// master drives samples and observes writes; slave is the capture writer.
interface capture_writer_if
    import capture_pkg::*;
#(
    parameter int AddrWidth = ADDR_W,
    parameter int DataWidth = SAMPLE_W
) ();

    logic [DataWidth-1:0] sample_in;
    logic                 sample_valid;
    logic                 wr_en;
    logic [AddrWidth-1:0] wr_addr;
    logic [DataWidth-1:0] wr_data;

    modport master (
        output sample_in,
        output sample_valid,
        input  wr_en,
        input  wr_addr,
        input  wr_data
    );

    modport slave (
        input  sample_in,
        input  sample_valid,
        output wr_en,
        output wr_addr,
        output wr_data
    );

endinterface

// File: rtl/sync_edge.sv
// sync_edge: 2-flop synchronizer followed by a rising-edge detector.
// Usable for any slow asynchronous pin (trigger, ncs, sck).
module sync_edge (
    input  logic clk,
    input  logic nreset,
    input  logic din,
    output logic rise
);

    logic s1;
    logic s2;
    logic s3;

    // Resynchronize the pin and keep one extra stage for edge detection
    always_ff @(posedge clk) begin
        if (!nreset) begin
            s1 <= 1'b0;
            s2 <= 1'b0;
            s3 <= 1'b0;
        end else begin
            s1 <= din;
            s2 <= s1;
            s3 <= s2;
        end
    end

    assign rise = s2 & ~s3;

endmodule

// File: rtl/capture_writer.sv
// capture_writer: streams samples into a circular RAM, stops after trigger.
// Build option LEVEL_TRIGGER_EN adds a sample-threshold trigger source.
module capture_writer
    import capture_pkg::*;
#(
    parameter int AddrWidth  = ADDR_W,
    parameter int DataWidth  = SAMPLE_W,
    parameter int PreTrigger = 1024
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic                 arm,
    input  logic                 trigger,
`ifdef LEVEL_TRIGGER_EN
    input  logic [7:0]           level,
    input  logic                 level_en,
`endif
    capture_writer_if.slave      bus,
    output logic [AddrWidth-1:0] start_addr,
    output logic                 ready,
    output logic                 busy
);

    localparam int CntWidth = AddrWidth + 1;
    localparam logic [CntWidth-1:0] PreCnt =
        CntWidth'(PreTrigger);
    localparam logic [CntWidth-1:0] PostCnt =
        CntWidth'(post_count(AddrWidth, PreTrigger));

    state_t                state;
    logic [AddrWidth-1:0]  ptr;
    logic [CntWidth-1:0]   pre_cnt;
    logic [CntWidth-1:0]   post_cnt;
    logic [CntWidth-1:0]   post_nxt;
    logic                  pin_edge;
    logic                  trig_edge;
    logic                  accept;
    logic                  in_post;
    logic                  finish;

    sync_edge u_trig_sync (
        .clk    (clk),
        .nreset (nreset),
        .din    (trigger),
        .rise   (pin_edge)
    );

`ifdef LEVEL_TRIGGER_EN
    logic [7:0] prev_hi;
    logic [7:0] cur_hi;
    logic       level_hit;

    assign cur_hi    = bus.sample_in[DataWidth-1 -: 8];
    assign level_hit = level_en && bus.sample_valid &&
                       (cur_hi >= level) && (prev_hi < level);

    // Remember the previous valid sample's high byte for crossing detection
    always_ff @(posedge clk) begin
        if (!nreset) begin
            prev_hi <= '0;
        end else if (bus.sample_valid) begin
            prev_hi <= cur_hi;
        end
    end

    assign trig_edge = pin_edge | level_hit;
`else
    assign trig_edge = pin_edge;
`endif

    // A trigger only counts once the pre-trigger history is full
    assign accept   = (state == ARMED) && trig_edge && (pre_cnt == PreCnt);
    assign in_post  = accept || (state == POST);
    assign post_nxt = (accept ? '0 : post_cnt) +
                      CntWidth'(bus.sample_valid);
    assign finish   = in_post && bus.sample_valid && (post_nxt == PostCnt);

    // Capture FSM with registered RAM write port and status outputs
    always_ff @(posedge clk) begin
        if (!nreset) begin
            state       <= IDLE;
            ptr         <= '0;
            pre_cnt     <= '0;
            post_cnt    <= '0;
            bus.wr_en   <= 1'b0;
            bus.wr_addr <= '0;
            bus.wr_data <= '0;
            start_addr  <= '0;
            ready       <= 1'b0;
            busy        <= 1'b0;
        end else begin
            bus.wr_en <= 1'b0;
            unique case (state)
                IDLE, DONE: begin
                    if (arm) begin
                        state    <= ARMED;
                        ptr      <= '0;
                        pre_cnt  <= '0;
                        post_cnt <= '0;
                        ready    <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                ARMED, POST: begin
                    if (arm) begin
                        state    <= ARMED;
                        ptr      <= '0;
                        pre_cnt  <= '0;
                        post_cnt <= '0;
                    end else begin
                        if (bus.sample_valid) begin
                            bus.wr_en   <= 1'b1;
                            bus.wr_addr <= ptr;
                            bus.wr_data <= bus.sample_in;
                            ptr         <= ptr + AddrWidth'(1);
                        end
                        if (state == ARMED && !accept &&
                            bus.sample_valid && pre_cnt != PreCnt) begin
                            pre_cnt <= pre_cnt + CntWidth'(1);
                        end
                        if (in_post) begin
                            post_cnt <= post_nxt;
                            state    <= finish ? DONE : POST;
                        end
                        if (finish) begin
                            start_addr <= ptr + AddrWidth'(1);
                            ready      <= 1'b1;
                            busy       <= 1'b0;
                        end
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_capture_writer.sv
// tb_capture_writer: randomized self-checking bench for capture_writer.
// Expected writes come from an arithmetic model over the logged stimulus.
module tb_capture_writer;

    localparam int AW    = 4;
    localparam int DW    = 16;
    localparam int PRE   = 4;
    localparam int POSTN = 12;
    localparam int MAXS  = 8192;

    typedef struct packed {
        logic [31:0]   st;
        logic [AW-1:0] a;
        logic [DW-1:0] d;
    } wr_t;

    logic          clk = 1'b0;
    logic          nreset = 1'b0;
    logic          arm = 1'b0;
    logic          trigger = 1'b0;
    logic [AW-1:0] start_addr;
    logic          ready;
    logic          busy;
`ifdef LEVEL_TRIGGER_EN
    logic [7:0]    level = 8'h00;
    logic          level_en = 1'b0;
`endif

    capture_writer_if #(.AddrWidth(AW), .DataWidth(DW)) bus ();

    capture_writer #(
        .AddrWidth  (AW),
        .DataWidth  (DW),
        .PreTrigger (PRE)
    ) dut (
        .clk        (clk),
        .nreset     (nreset),
        .arm        (arm),
        .trigger    (trigger),
`ifdef LEVEL_TRIGGER_EN
        .level      (level),
        .level_en   (level_en),
`endif
        .bus        (bus),
        .start_addr (start_addr),
        .ready      (ready),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_fail = 0;
    int          cur = 0;
    int          last_idx = 0;
    int          rst_idx = 0;
    logic [15:0] dcnt = 16'h0;
    bit          lv [MAXS];
    bit          lp [MAXS];
    logic [DW-1:0] ld [MAXS];
    wr_t         obs [$];
    wr_t         win [$];
    wr_t         expq [$];
    bit          exp_done;
    logic [AW-1:0] exp_start;

    // Log what the DUT saw at every rising edge
    always @(posedge clk) begin
        if (cur < MAXS) begin
            lv[cur] <= bus.sample_valid;
            lp[cur] <= trigger;
            ld[cur] <= bus.sample_in;
        end
        cur <= cur + 1;
    end

    // Collect RAM writes tagged with the edge that produced them
    always @(negedge clk) begin
        if (bus.wr_en === 1'b1)
            obs.push_back({32'(cur - 1), bus.wr_addr, bus.wr_data});
    end

    task automatic step(input bit v, input bit a, input bit p,
                        input logic [DW-1:0] d);
        @(negedge clk);
        bus.sample_valid = v;
        arm = a;
        trigger = p;
        bus.sample_in = d;
        last_idx = cur;
    endtask

    task automatic peek();
        @(posedge clk);
        #1;
    endtask

    task automatic flush();
        @(negedge clk);
        #1;
    endtask

    function automatic void window(int lo, int hi);
        win.delete();
        foreach (obs[i])
            if (int'(obs[i].st) >= lo && int'(obs[i].st) <= hi)
                win.push_back(obs[i]);
    endfunction

    // Reference: arm at edge a0; every valid sample after it is written in
    // order to ring slot n mod 16; the pin edge seen at e is pin(e-2)&~pin(e-3);
    // capture ends on the POSTN-th sample from the first accepted trigger.
    function automatic void predict(int a0, int last);
        int pre;
        int post;
        int n;
        bit trig;
        pre = 0;
        post = 0;
        n = 0;
        trig = 0;
        expq.delete();
        exp_done = 0;
        exp_start = '0;
        for (int e = a0 + 1; e <= last; e++) begin
            bit tr;
            tr = lp[e-2] & ~lp[e-3];
`ifdef LEVEL_TRIGGER_EN
            if (level_en && lv[e]) begin
                logic [7:0] pv;
                pv = 8'h00;
                for (int j = e - 1; j >= rst_idx; j--)
                    if (lv[j]) begin
                        pv = ld[j][DW-1 -: 8];
                        break;
                    end
                if (ld[e][DW-1 -: 8] >= level && pv < level) tr = 1;
            end
`endif
            if (!trig && tr && pre >= PRE) trig = 1;
            if (lv[e]) begin
                expq.push_back({32'(e), AW'(n), ld[e]});
                n++;
                if (!trig) begin
                    pre++;
                end else begin
                    post++;
                    if (post == POSTN) begin
                        exp_done = 1;
                        exp_start = AW'(n);
                        break;
                    end
                end
            end
        end
    endfunction

    task automatic test_reset();
        nreset = 1'b0;
        repeat (3) step(0, 1, 0, 16'h0);
        peek();
        n_chk += 6;
        if (bus.wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_wr_en: got %b expected 0", bus.wr_en);
        end
        if (bus.wr_addr !== '0) begin
            n_fail++;
            $display("FAIL rst_wr_addr: got %h expected 0", bus.wr_addr);
        end
        if (bus.wr_data !== '0) begin
            n_fail++;
            $display("FAIL rst_wr_data: got %h expected 0", bus.wr_data);
        end
        if (start_addr !== '0) begin
            n_fail++;
            $display("FAIL rst_start: got %h expected 0", start_addr);
        end
        if (ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_ready: got %b expected 0", ready);
        end
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_busy: got %b expected 0", busy);
        end
        step(0, 0, 0, 16'h0);
        nreset = 1'b1;
        rst_idx = last_idx;
        repeat (3) step(0, 0, 0, 16'h0);
        peek();
        n_chk++;
        if (busy !== 1'b0 || ready !== 1'b0) begin
            n_fail++;
            $display("FAIL rst_arm_ignored: busy=%b ready=%b expected 0 0",
                     busy, ready);
        end
    endtask

    task automatic test_capture();
        int a0;
        obs.delete();
        repeat (3) step(0, 0, 0, 16'h0);
        step(0, 1, 0, dcnt);
        a0 = last_idx;
        for (int k = 1; k <= 30; k++) begin
            step(1, 0, (k <= 3) || (k >= 5), dcnt);
            dcnt++;
            if (k == 3) begin
                peek();
                n_chk++;
                if (busy !== 1'b1 || ready !== 1'b0) begin
                    n_fail++;
                    $display("FAIL cap_early: busy=%b ready=%b expected 1 0",
                             busy, ready);
                end
            end
        end
        step(0, 0, 0, 16'h0);
        flush();
        predict(a0, cur - 1);
        window(a0, cur - 1);
        n_chk++;
        if (win.size() != expq.size()) begin
            n_fail++;
            $display("FAIL cap_count: got %0d expected %0d",
                     win.size(), expq.size());
        end
        foreach (expq[i])
            if (i < win.size()) begin
                n_chk++;
                if (win[i] !== expq[i]) begin
                    n_fail++;
                    $display("FAIL cap_write[%0d]: got %h expected %h",
                             i, win[i], expq[i]);
                end
            end
        n_chk += 3;
        if (ready !== exp_done) begin
            n_fail++;
            $display("FAIL cap_ready: got %b expected %b", ready, exp_done);
        end
        if (busy !== !exp_done) begin
            n_fail++;
            $display("FAIL cap_busy: got %b expected %b", busy, !exp_done);
        end
        if (start_addr !== 4'd2) begin
            n_fail++;
            $display("FAIL cap_start: got %0d expected 2", start_addr);
        end
    endtask

    task automatic test_gated();
        int a0;
        int r;
        obs.delete();
        r = int'($urandom_range(14, 19));
        repeat (3) step(0, 0, 0, 16'h0);
        step(0, 1, 0, dcnt);
        a0 = last_idx;
        for (int k = 1; k <= 70; k++) begin
            step(k % 3 == 0, 0, k >= r, dcnt);
            dcnt++;
        end
        step(0, 0, 0, 16'h0);
        flush();
        predict(a0, cur - 1);
        window(a0, cur - 1);
        n_chk++;
        if (win.size() != expq.size()) begin
            n_fail++;
            $display("FAIL gate_count: got %0d expected %0d",
                     win.size(), expq.size());
        end
        foreach (expq[i])
            if (i < win.size()) begin
                n_chk++;
                if (win[i] !== expq[i]) begin
                    n_fail++;
                    $display("FAIL gate_write[%0d]: got %h expected %h",
                             i, win[i], expq[i]);
                end
            end
        n_chk += 2;
        if (ready !== exp_done || !exp_done) begin
            n_fail++;
            $display("FAIL gate_ready: got %b expected 1", ready);
        end
        if (start_addr !== exp_start) begin
            n_fail++;
            $display("FAIL gate_start: got %0d expected %0d",
                     start_addr, exp_start);
        end
    endtask

    task automatic test_restart();
        int a0;
        int a1;
        obs.delete();
        repeat (3) step(0, 0, 0, 16'h0);
        step(0, 1, 0, dcnt);
        a0 = last_idx;
        for (int k = 1; k <= 11; k++) begin
            step(1, 0, k >= 5, dcnt);
            dcnt++;
        end
        step(1, 1, 1, dcnt);
        dcnt++;
        a1 = last_idx;
        peek();
        n_chk++;
        if (ready !== 1'b0 || busy !== 1'b1) begin
            n_fail++;
            $display("FAIL rs_state: ready=%b busy=%b expected 0 1",
                     ready, busy);
        end
        for (int k = 1; k <= 30; k++) begin
            step(1, 0, (k == 2) || (k == 3) || (k >= 6), dcnt);
            dcnt++;
        end
        step(0, 0, 0, 16'h0);
        flush();
        predict(a0, a1 - 1);
        window(a0, a1 - 1);
        n_chk += 2;
        if (exp_done || win.size() != 11) begin
            n_fail++;
            $display("FAIL rs_first_count: got %0d expected 11", win.size());
        end
        if (win.size() != expq.size()) begin
            n_fail++;
            $display("FAIL rs_first_model: got %0d expected %0d",
                     win.size(), expq.size());
        end
        predict(a1, cur - 1);
        window(a1, cur - 1);
        n_chk++;
        if (win.size() != expq.size()) begin
            n_fail++;
            $display("FAIL rs_count: got %0d expected %0d",
                     win.size(), expq.size());
        end
        foreach (expq[i])
            if (i < win.size()) begin
                n_chk++;
                if (win[i] !== expq[i]) begin
                    n_fail++;
                    $display("FAIL rs_write[%0d]: got %h expected %h",
                             i, win[i], expq[i]);
                end
            end
        n_chk += 2;
        if (ready !== exp_done) begin
            n_fail++;
            $display("FAIL rs_ready: got %b expected %b", ready, exp_done);
        end
        if (start_addr !== exp_start) begin
            n_fail++;
            $display("FAIL rs_start: got %0d expected %0d",
                     start_addr, exp_start);
        end
    endtask

    task automatic test_random();
        for (int it = 0; it < 4; it++) begin
            int a0;
            bit p;
            obs.delete();
            p = 0;
            repeat (3) step(0, 0, 0, 16'h0);
            step(0, 1, 0, 16'(($urandom)));
            a0 = last_idx;
            for (int k = 1; k <= 80; k++) begin
                if ($urandom_range(0, 7) == 0) p = !p;
                step($urandom_range(0, 3) != 0, 0, p, 16'($urandom));
            end
            repeat (3) step(0, 0, 0, 16'h0);
            flush();
            predict(a0, cur - 1);
            window(a0, cur - 1);
            n_chk++;
            if (win.size() != expq.size()) begin
                n_fail++;
                $display("FAIL rnd%0d_count: got %0d expected %0d",
                         it, win.size(), expq.size());
            end
            foreach (expq[i])
                if (i < win.size()) begin
                    n_chk++;
                    if (win[i] !== expq[i]) begin
                        n_fail++;
                        $display("FAIL rnd%0d_write[%0d]: got %h expected %h",
                                 it, i, win[i], expq[i]);
                    end
                end
            n_chk += 2;
            if (ready !== exp_done || busy !== !exp_done) begin
                n_fail++;
                $display("FAIL rnd%0d_flags: ready=%b busy=%b done=%b",
                         it, ready, busy, exp_done);
            end
            if (exp_done && start_addr !== exp_start) begin
                n_fail++;
                $display("FAIL rnd%0d_start: got %0d expected %0d",
                         it, start_addr, exp_start);
            end
        end
    endtask

    task automatic test_reset_armed();
        int r;
        obs.delete();
        repeat (3) step(0, 0, 0, 16'h0);
        step(0, 1, 0, dcnt);
        repeat (3) begin
            step(1, 0, 0, dcnt);
            dcnt++;
        end
        step(1, 0, 0, dcnt);
        nreset = 1'b0;
        r = last_idx;
        peek();
        n_chk += 2;
        if (busy !== 1'b0 || ready !== 1'b0) begin
            n_fail++;
            $display("FAIL ra_state: busy=%b ready=%b expected 0 0",
                     busy, ready);
        end
        if (bus.wr_en !== 1'b0) begin
            n_fail++;
            $display("FAIL ra_wr_en: got %b expected 0", bus.wr_en);
        end
        step(1, 0, 0, dcnt);
        nreset = 1'b1;
        rst_idx = last_idx;
        for (int k = 1; k <= 20; k++) begin
            step(1, 0, (k % 6) >= 3, dcnt);
            dcnt++;
        end
        step(0, 0, 0, 16'h0);
        flush();
        window(r, cur - 1);
        n_chk += 2;
        if (win.size() != 0) begin
            n_fail++;
            $display("FAIL ra_writes: got %0d expected 0", win.size());
        end
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ra_busy: got %b expected 0", busy);
        end
    endtask

`ifdef LEVEL_TRIGGER_EN
    task automatic test_level();
        int a0;
        logic [7:0] hi;
        obs.delete();
        level = 8'h20;
        level_en = 1'b1;
        repeat (3) step(0, 0, 0, 16'h0);
        step(0, 1, 0, 16'h0);
        a0 = last_idx;
        for (int k = 1; k <= 25; k++) begin
            hi = (k <= 6) ? 8'h10 : (k == 7) ? 8'h1F :
                 (k == 8) ? 8'h20 : 8'h21;
            step(1, 0, 0, {hi, 8'(k)});
        end
        step(0, 0, 0, 16'h0);
        flush();
        predict(a0, cur - 1);
        window(a0, cur - 1);
        n_chk += 3;
        if (win.size() != expq.size() || win.size() != 19) begin
            n_fail++;
            $display("FAIL lvl_count: got %0d expected 19", win.size());
        end
        if (ready !== 1'b1 || !exp_done) begin
            n_fail++;
            $display("FAIL lvl_ready: got %b expected 1", ready);
        end
        if (start_addr !== exp_start) begin
            n_fail++;
            $display("FAIL lvl_start: got %0d expected %0d",
                     start_addr, exp_start);
        end
        obs.delete();
        step(0, 1, 0, 16'h0);
        a0 = last_idx;
        for (int k = 1; k <= 25; k++) begin
            hi = (k <= 8) ? 8'h20 : 8'h21;
            step(1, 0, 0, {hi, 8'(k)});
        end
        step(0, 0, 0, 16'h0);
        flush();
        predict(a0, cur - 1);
        n_chk += 2;
        if (ready !== exp_done || ready !== 1'b0) begin
            n_fail++;
            $display("FAIL lvl_noretrig: ready=%b expected 0", ready);
        end
        if (busy !== 1'b1) begin
            n_fail++;
            $display("FAIL lvl_busy: got %b expected 1", busy);
        end
        level_en = 1'b0;
    endtask
`endif

    initial begin
        bus.sample_valid = 1'b0;
        bus.sample_in = '0;
        test_reset();
        test_capture();
        test_gated();
        test_restart();
        test_random();
        test_reset_armed();
`ifdef LEVEL_TRIGGER_EN
        test_level();
`endif
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/capture_writer.md
Name: capture_writer

Overview:
- Write side of the sample memory that the SPI block reads through mem_addr/mem_data.
- Streams ADC sample pairs into a circular buffer while armed.
- Waits for the MCU trigger, records a fixed number of post-trigger samples, then freezes the buffer and raises ready so the MCU can read it out over SPI.
- Sits between the ADC input register and the dual-port sample RAM.

Parameters:
AddrWidth, 12, sample RAM address width; depth = 2**AddrWidth
DataWidth, 16, sample width ({adc_a, adc_b})
PreTrigger, 1024, samples required before a trigger is accepted; must be < 2**AddrWidth

Ports:
clk  in  1  system clock; all logic on rising edge
nreset  in  1  synchronous active-low reset
arm  in  1  one-cycle pulse (from SPI command register) starting a capture
trigger  in  1  MCU trigger pin, asynchronous to clk
sample_in  in  DataWidth  registered ADC pair
sample_valid  in  1  sample strobe; 1 = write sample_in this cycle
wr_en  out  1  RAM write enable
wr_addr  out  AddrWidth  RAM write address
wr_data  out  DataWidth  RAM write data
start_addr  out  AddrWidth  address of the oldest sample in a completed capture
ready  out  1  capture complete, buffer frozen
busy  out  1  in ARMED or POST

Behaviour:
- Reset (nreset=0 at a clk edge): state IDLE, wr_en=0, wr_addr=0, wr_data=0, start_addr=0, ready=0, busy=0, all counters 0. Reset mid-capture aborts immediately; RAM contents are undefined to the reader.
- Trigger path: 2-flop synchronizer plus an edge register. trig_edge = s2 & ~s3. A rising input is recognized 2-3 cycles after the pin rises. Level-high input does not retrigger.
- Write timing: registered. When sample_valid=1 in ARMED/POST at edge N, then at N+1: wr_en=1, wr_data=sample_in, and wr_addr is the current pointer. The pointer increments after the write and wraps 2**AddrWidth-1 -> 0. wr_en=0 otherwise.
- IDLE: no writes, busy=0. arm -> ARMED with pointer=0, pre_cnt=0, ready=0.
- ARMED: busy=1. Each valid sample increments pre_cnt, saturating at PreTrigger. trig_edge with pre_cnt < PreTrigger is ignored and not queued. trig_edge with pre_cnt == PreTrigger -> POST with post_cnt=0.
- POST: the sample with sample_valid in the trig_edge cycle is the first post-trigger sample. Each valid sample increments post_cnt. When post_cnt reaches Post = 2**AddrWidth - PreTrigger -> DONE. start_addr latches the pointer value after the last write (the oldest sample).
- DONE: ready=1, busy=0, no writes. arm -> ARMED (ready drops the next cycle). trigger is ignored.
- arm in ARMED or POST restarts the capture: pointer=0, counters=0, state ARMED.
- Simultaneous arm and trig_edge: arm wins.
- Simultaneous sample_valid and the POST->DONE transition: that sample is the last one written.
- Counters: pre_cnt and post_cnt are AddrWidth+1 bits wide. No overflow is possible.

Optional Feature:
LEVEL_TRIGGER_EN
- Defined: adds input level [7:0] and input level_en. In ARMED, a valid sample with sample_in[15:8] >= level, where the previous valid sample's [15:8] < level, acts as trig_edge when level_en=1. This is OR'ed with the pin trigger and obeys the same pretrigger rule.
- Not defined: ports are absent and only the pin trigger is used.

Decomposition:
- Package capture_pkg holds:
  - state enum (IDLE, ARMED, POST, DONE)
  - default widths (ADDR_W=12, SAMPLE_W=16)
  - localparam function for the post-trigger count
- One natural sub-module, sync_edge: 2-flop synchronizer plus rising-edge detector, reset via nreset, also reusable for ncs/sck.

Test Plan:
(Bench: AddrWidth=4, PreTrigger=4, so Post=12, with continuous sample_valid and sample_in = incrementing count.)
- Reset held 3 cycles, then released -> all outputs 0, state IDLE. arm while nreset=0 -> ignored.
- arm, then trigger raised after 2 samples and held high -> no capture yet. Drop and re-raise trigger after 6 samples -> exactly 12 post writes, ready=1, busy=0, start_addr = (18 mod 16) = 2.
- Gated sample_valid (1 of every 3 cycles) -> wr_en pulses only 1 cycle after each strobe; wr_addr wraps 15->0; post count still 12 samples.
- arm asserted during POST after 5 post samples -> ready stays 0, pointer restarts at 0, pre_cnt restarts.
- nreset pulsed during ARMED -> next cycle IDLE, wr_en=0. A trigger afterwards produces no writes.
- With LEVEL_TRIGGER_EN and level=8'h20: sample [15:8] rising 0x1F->0x20 after pretrigger -> capture starts on that sample. A 0x20->0x21 step does not retrigger.
